// File: rtl/prio_enc_pkg.sv
// Shared definitions for the sequential priority encoder.
//   MODE_ONEHOT / MODE_SCAN : values for the MODE parameter of prio_encode_seq
//   state_e                 : two-state control FSM encoding (IDLE, BUSY)
package prio_enc_pkg;

  localparam int unsigned MODE_ONEHOT = 0;
  localparam int unsigned MODE_SCAN   = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage : prio_enc_pkg

// File: rtl/lsb_index.sv
// Combinational lowest-set-bit locator.
//   vec_i : input bit vector (N bits)
//   idx_o : index of the lowest set bit, 0 when vec_i is all zero
//   any_o : at least one bit of vec_i is set
//   one_o : exactly one bit of vec_i is set
module lsb_index #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic         one_o
);

  // Walk from the top down so the lowest set bit wins the last assignment.
  always_comb begin
    idx_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |vec_i;
  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign one_o = any_o && ((vec_i & (vec_i - N'(1))) == '0);

endmodule : lsb_index

// File: rtl/prio_encode_seq.sv
// Registered priority encoder with valid/ready on both sides.
//   clk, rst        : clock, synchronous active-high reset
//   en              : 1 blocks new captures (an in-flight vector still drains)
//   in_valid/ready  : input handshake, din is the N-bit request vector
//   out_valid/ready : output handshake for dout / dout_last / err
//   dout            : binary index of the emitted bit
//   dout_last       : final beat of the current vector
//   err             : malformed vector (ONEHOT: not exactly one bit; SCAN: zero)
module prio_encode_seq
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N    = 8,
  parameter  int unsigned MODE = MODE_ONEHOT,
  localparam int unsigned W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic         dout_last,
  output logic         err
);

  state_e         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic           valid_q, valid_d;

  logic [N-1:0]   mask_rem;
  logic [N-1:0]   lsb_src;
  logic [W-1:0]   lsb_idx;
  logic           lsb_any;
  logic           lsb_one;

  // Mask with the bit currently on dout removed: what remains after this beat.
  assign mask_rem = mask_q & ~(N'(1) << dout_q);

  // One locator serves both the capture (din) and the scan advance (mask).
  assign lsb_src = (state_q == IDLE) ? din : mask_rem;

  lsb_index #(
    .N (N),
    .W (W)
  ) u_lsb_index (
    .vec_i (lsb_src),
    .idx_o (lsb_idx),
    .any_o (lsb_any),
    .one_o (lsb_one)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dout_d  = dout_q;
    last_d  = last_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = BUSY;
          valid_d = 1'b1;
          mask_d  = din;
          dout_d  = '0;
          err_d   = 1'b1;
          last_d  = 1'b1;
          if (MODE == MODE_SCAN) begin
            if (lsb_any) begin
              dout_d = lsb_idx;
              err_d  = 1'b0;
              last_d = lsb_one;
            end
          end else if (lsb_one) begin
            dout_d = lsb_idx;
            err_d  = 1'b0;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            mask_d  = '0;
          end else begin
            mask_d = mask_rem;
            dout_d = lsb_idx;
            last_d = lsb_one;
            err_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // in_ready depends only on registered state and en, never on out_ready.
  assign in_ready  = (state_q == IDLE) && !en;
  assign out_valid = valid_q;
  assign dout      = dout_q;
  assign dout_last = last_q;
  assign err       = err_q;

endmodule : prio_encode_seq

// File: tb/tb_prio_encode_seq.sv
// Self-checking bench: three instances (ONEHOT N=8, SCAN N=8, SCAN N=5)
// share stimulus; sel picks which one receives in_valid and is observed.
module tb_prio_encode_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] din8 = '0;
  int         sel = 0;

  logic       iv0, iv1, iv2;
  logic       ir0, ir1, ir2;
  logic       ov0, ov1, ov2;
  logic       l0, l1, l2;
  logic       e0, e1, e2;
  logic [2:0] d0, d1, d2;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  prio_encode_seq #(.N(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv0), .in_ready(ir0), .din(din8),
    .out_valid(ov0), .out_ready(out_ready), .dout(d0), .dout_last(l0), .err(e0));

  prio_encode_seq #(.N(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv1), .in_ready(ir1), .din(din8),
    .out_valid(ov1), .out_ready(out_ready), .dout(d1), .dout_last(l1), .err(e1));

  prio_encode_seq #(.N(5), .MODE(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv2), .in_ready(ir2), .din(din8[4:0]),
    .out_valid(ov2), .out_ready(out_ready), .dout(d2), .dout_last(l2), .err(e2));

  logic       obs_valid, obs_ready, obs_last, obs_err;
  logic [7:0] obs_dout;

  always_comb begin
    obs_valid = ov0; obs_ready = ir0; obs_last = l0; obs_err = e0; obs_dout = {5'b0, d0};
    if (sel == 1) begin
      obs_valid = ov1; obs_ready = ir1; obs_last = l1; obs_err = e1; obs_dout = {5'b0, d1};
    end else if (sel == 2) begin
      obs_valid = ov2; obs_ready = ir2; obs_last = l2; obs_err = e2; obs_dout = {5'b0, d2};
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  // Reference beats for one vector, pushed when the vector is driven.
  task automatic expect_vec(input logic [7:0] v, input int n, input int mode);
    int cnt = 0;
    int k = 0;
    for (int i = 0; i < n; i++) if (v[i]) cnt++;
    if (mode == 0) begin
      if (cnt == 1) begin
        for (int i = 0; i < n; i++) if (v[i]) exp_q.push_back({8'(i), 1'b1, 1'b0});
      end else begin
        exp_q.push_back({8'd0, 1'b1, 1'b1});
      end
    end else if (cnt == 0) begin
      exp_q.push_back({8'd0, 1'b1, 1'b1});
    end else begin
      for (int i = 0; i < n; i++) begin
        if (v[i]) begin
          k++;
          exp_q.push_back({8'(i), (k == cnt), 1'b0});
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after capture.
  task automatic send(input logic [7:0] v);
    int w = 0;
    while (!obs_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (obs_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready sel=%0d in_ready=%b required 1", sel, obs_ready);
    end
    in_valid = 1'b1;
    din8 = v;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (obs_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency sel=%0d out_valid=%b required 1", sel, obs_valid);
    end
    tests++;
    if (obs_ready !== 1'b0) begin
      fails++;
      $display("FAIL in_ready_drop sel=%0d in_ready=%b required 0", sel, obs_ready);
    end
  endtask

  // Pops the scoreboard as beats complete; pat[j] is out_ready on cycle j.
  task automatic drain(input logic [15:0] pat, input int plen);
    int    c = 0;
    int    j = 0;
    bit    stall = 1'b0;
    beat_t held, got, exp;
    held = '0;
    while (exp_q.size() > 0 && c < 64) begin
      out_ready = (j < plen) ? pat[j] : 1'b1;
      j++;
      got = {obs_dout, obs_last, obs_err};
      if (stall) begin
        tests++;
        if (got !== held) begin
          fails++;
          $display("FAIL stall_hold sel=%0d got d=%0d l=%b e=%b required d=%0d l=%b e=%b",
                   sel, got.d, got.l, got.e, held.d, held.l, held.e);
        end
        stall = 1'b0;
      end
      if (obs_valid === 1'b1) begin
        tests++;
        if (obs_ready !== 1'b0) begin
          fails++;
          $display("FAIL in_ready_busy sel=%0d in_ready=%b required 0", sel, obs_ready);
        end
        if (out_ready) begin
          exp = exp_q.pop_front();
          tests++;
          if (got !== exp) begin
            fails++;
            $display("FAIL beat sel=%0d got d=%0d l=%b e=%b required d=%0d l=%b e=%b",
                     sel, got.d, got.l, got.e, exp.d, exp.l, exp.e);
          end
        end else begin
          stall = 1'b1;
          held = got;
        end
      end
      @(negedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout sel=%0d beats left=%0d required 0", sel, exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
    tests++;
    if (obs_valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_drop sel=%0d out_valid=%b required 0", sel, obs_valid);
    end
    tests++;
    if (obs_ready !== !en) begin
      fails++;
      $display("FAIL in_ready_return sel=%0d in_ready=%b required %b", sel, obs_ready, !en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      tests++;
      if ({obs_valid, obs_dout, obs_last, obs_err, obs_ready} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL reset_state sel=%0d got v=%b d=%0d l=%b e=%b rdy=%b required v=0 d=0 l=0 e=0 rdy=1",
                 s, obs_valid, obs_dout, obs_last, obs_err, obs_ready);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_onehot();
    logic [7:0] vecs [5];
    vecs = '{8'b0010_0000, 8'b0100_0100, 8'b0000_0000, 8'b1000_0000, 8'b0000_0001};
    sel = 0;
    foreach (vecs[i]) begin
      expect_vec(vecs[i], 8, 0);
      send(vecs[i]);
      drain(16'hFFFF, 0);
    end
  endtask

  task automatic test_scan();
    sel = 1;
    expect_vec(8'b1001_0010, 8, 1);
    send(8'b1001_0010);
    drain(16'h000D, 4);
    expect_vec(8'b0000_0000, 8, 1);
    send(8'b0000_0000);
    drain(16'hFFFF, 0);
    expect_vec(8'b1111_1111, 8, 1);
    send(8'b1111_1111);
    drain(16'h0155, 9);
  endtask

  task automatic test_scan_n5();
    sel = 2;
    expect_vec(8'b0001_1111, 5, 1);
    send(8'b0001_1111);
    drain(16'hFFFF, 0);
    expect_vec(8'b0001_0100, 5, 1);
    send(8'b0001_0100);
    drain(16'h0005, 3);
  endtask

  task automatic test_en();
    sel = 0;
    en = 1'b1;
    in_valid = 1'b1;
    din8 = 8'b0010_0000;
    #1;
    tests++;
    if (obs_ready !== 1'b0) begin
      fails++;
      $display("FAIL en_block_ready in_ready=%b required 0", obs_ready);
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs_valid !== 1'b0) begin
        fails++;
        $display("FAIL en_no_capture out_valid=%b required 0", obs_valid);
      end
    end
    in_valid = 1'b0;
    en = 1'b0;
    @(negedge clk);
    sel = 1;
    expect_vec(8'b1110_0000, 8, 1);
    send(8'b1110_0000);
    en = 1'b1;
    drain(16'hFFFF, 0);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    sel = 1;
    send(8'b0000_1111);
    out_ready = 1'b1;
    tests++;
    if (obs_dout !== 8'd0) begin
      fails++;
      $display("FAIL mid_first_beat dout=%0d required 0", obs_dout);
    end
    @(negedge clk);
    tests++;
    if (obs_dout !== 8'd1 || obs_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_second_beat dout=%0d v=%b required dout=1 v=1", obs_dout, obs_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({obs_valid, obs_dout, obs_last, obs_err} !== {1'b0, 8'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset got v=%b d=%0d l=%b e=%b required all 0",
               obs_valid, obs_dout, obs_last, obs_err);
    end
    tests++;
    if (dut1.mask_q !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset_mask mask=%b required 0", dut1.mask_q);
    end
    expect_vec(8'b1000_0000, 8, 1);
    send(8'b1000_0000);
    drain(16'hFFFF, 0);
  endtask

  task automatic test_rst_vs_capture();
    sel = 0;
    rst = 1'b1;
    in_valid = 1'b1;
    din8 = 8'b0010_0000;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      tests++;
      if (obs_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_wins out_valid=%b required 0", obs_valid);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_scan();
    test_scan_n5();
    test_en();
    test_reset_mid();
    test_rst_vs_capture();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_prio_encode_seq
